// File: rtl/zap_fetch_pc_gen.sv
// Fetch program-counter generator: sequential advance, execute redirects and BTB redirects.
// Optional redirect statistics outputs are enabled with ZAP_FETCH_REDIRECT_STATS_EN.
module zap_fetch_pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_clear,
  input  logic [31:0] i_clear_pc,
  input  logic        i_thumb,
  input  logic        i_clear_from_btb,
  input  logic [31:0] i_pc_from_btb,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_del,
  output logic        o_pc_valid,
  output logic        o_pred_taken,
  output logic        o_kill
`ifdef ZAP_FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0] o_btb_redirect_cnt,
  output logic [31:0] o_btb_suppress_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_del_q, pc_del_d;
  logic        valid_q;
  logic        pred_q, pred_d;
  logic        kill_q, kill_d;
  logic [1:0]  supp_q, supp_d;
  logic        btb_take;
  logic        btb_masked;
  logic [31:0] step;

  function automatic logic [31:0] align_pc(input logic [31:0] addr, input logic thumb);
    return thumb ? {addr[31:1], 1'b0} : {addr[31:2], 2'b00};
  endfunction

  assign step       = i_thumb ? 32'd2 : 32'd4;
  assign btb_take   = i_clear_from_btb && !i_clear && !i_stall && (supp_q == 2'd0);
  // Dropped either by a same-cycle execute redirect or by the post-redirect lookup window.
  assign btb_masked = i_clear_from_btb && (i_clear || (!i_stall && (supp_q != 2'd0)));

  always_comb begin
    pc_d     = pc_q;
    pc_del_d = pc_del_q;
    pred_d   = pred_q;
    kill_d   = 1'b0;
    supp_d   = supp_q;
    if (i_clear) begin
      pc_d     = align_pc(i_clear_pc, i_thumb);
      pc_del_d = pc_q;
      pred_d   = 1'b0;
      supp_d   = 2'd2;
    end else if (btb_take) begin
      pc_d     = align_pc(i_pc_from_btb, i_thumb);
      pc_del_d = pc_q;
      pred_d   = 1'b1;
      kill_d   = 1'b1;
      supp_d   = 2'd2;
    end else if (!i_stall) begin
      pc_d     = pc_q + step;
      pc_del_d = pc_q;
      pred_d   = 1'b0;
      supp_d   = (supp_q == 2'd0) ? 2'd0 : supp_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q     <= RESET_VECTOR;
      pc_del_q <= RESET_VECTOR;
      valid_q  <= 1'b0;
      pred_q   <= 1'b0;
      kill_q   <= 1'b0;
      supp_q   <= 2'd2;
    end else begin
      pc_q     <= pc_d;
      pc_del_q <= pc_del_d;
      valid_q  <= 1'b1;
      pred_q   <= pred_d;
      kill_q   <= kill_d;
      supp_q   <= supp_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_pc_del     = pc_del_q;
  assign o_pc_valid   = valid_q;
  assign o_pred_taken = pred_q;
  assign o_kill       = kill_q;

`ifdef ZAP_FETCH_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] suppress_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      redirect_cnt_q <= 32'd0;
      suppress_cnt_q <= 32'd0;
    end else begin
      if (btb_take) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (btb_masked) suppress_cnt_q <= suppress_cnt_q + 32'd1;
    end
  end

  assign o_btb_redirect_cnt = redirect_cnt_q;
  assign o_btb_suppress_cnt = suppress_cnt_q;
`endif

endmodule

// File: tb/tb_zap_fetch_pc_gen.sv
// Self-checking bench for zap_fetch_pc_gen: cycle model plus directed literal expectations.
module tb_zap_fetch_pc_gen;

  localparam logic [31:0] RV = 32'h100;

  logic        clk;
  logic        reset, stall, clear, thumb, btb;
  logic [31:0] clear_pc, btb_pc;
  logic [31:0] pc, pc_del;
  logic        pc_valid, pred_taken, kill;
`ifdef ZAP_FETCH_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt, suppress_cnt;
`endif

  int checks = 0;
  int failures = 0;

  zap_fetch_pc_gen #(.RESET_VECTOR(RV)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_stall          (stall),
    .i_clear          (clear),
    .i_clear_pc       (clear_pc),
    .i_thumb          (thumb),
    .i_clear_from_btb (btb),
    .i_pc_from_btb    (btb_pc),
    .o_pc             (pc),
    .o_pc_del         (pc_del),
    .o_pc_valid       (pc_valid),
    .o_pred_taken     (pred_taken),
    .o_kill           (kill)
`ifdef ZAP_FETCH_REDIRECT_STATS_EN
    ,
    .o_btb_redirect_cnt (redirect_cnt),
    .o_btb_suppress_cnt (suppress_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch address stream must look like after each edge.
  logic [31:0] m_pc, m_del, m_rcnt, m_scnt;
  logic        m_valid, m_pred, m_kill, m_started;
  int          m_lock;  // non-stalled cycles during which BTB pulses are still ignored

  initial begin
    m_started = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pc = RV; m_del = RV; m_valid = 0; m_pred = 0; m_kill = 0;
        m_lock = 2; m_rcnt = 0; m_scnt = 0; m_started = 1'b1;
      end else if (m_started) begin
        m_valid = 1;
        m_kill  = 0;
        if (clear) begin
          if (btb) m_scnt = m_scnt + 1;
          m_del  = m_pc;
          m_pc   = clear_pc & (thumb ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
          m_pred = 0;
          m_lock = 2;
        end else if (btb && !stall && m_lock == 0) begin
          m_rcnt = m_rcnt + 1;
          m_del  = m_pc;
          m_pc   = btb_pc & (thumb ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
          m_pred = 1;
          m_kill = 1;
          m_lock = 2;
        end else if (!stall) begin
          if (btb) m_scnt = m_scnt + 1;
          m_del  = m_pc;
          m_pc   = 32'((64'(m_pc) + (thumb ? 64'd2 : 64'd4)) % 64'h1_0000_0000);
          m_pred = 0;
          if (m_lock > 0) m_lock--;
        end
      end
    end
  end

  logic prev_kill = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("pc", pc, m_pc);
        chk("pc_del", pc_del, m_del);
        chk("pc_valid", 32'(pc_valid), 32'(m_valid));
        chk("pred_taken", 32'(pred_taken), 32'(m_pred));
        chk("kill", 32'(kill), 32'(m_kill));
        chk("kill_not_back_to_back", 32'(prev_kill && kill), 32'd0);
`ifdef ZAP_FETCH_REDIRECT_STATS_EN
        chk("redirect_cnt", redirect_cnt, m_rcnt);
        chk("suppress_cnt", suppress_cnt, m_scnt);
`endif
        prev_kill = kill;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1; stall = 0; clear = 0; thumb = 0; btb = 0; clear_pc = 0; btb_pc = 0;
    cyc(2);
    chk("rst_pc", pc, 32'h100);
    chk("rst_pc_del", pc_del, 32'h100);
    chk("rst_valid", 32'(pc_valid), 32'd0);
    chk("rst_kill", 32'(kill), 32'd0);
    reset = 0;
    cyc(1);
    chk("seq_pc1", pc, 32'h104);
    chk("seq_del1", pc_del, 32'h100);
    chk("seq_valid1", 32'(pc_valid), 32'd1);
    cyc(1);
    chk("seq_pc2", pc, 32'h108);
    chk("seq_del2", pc_del, 32'h104);

    // Reach 0x200, then redirect while stalled with a thumb target.
    clear = 1; clear_pc = 32'h200;
    cyc(1);
    chk("clr_pc_200", pc, 32'h200);
    stall = 1; clear_pc = 32'h1003; thumb = 1;
    cyc(1);
    chk("clr_stalled_pc", pc, 32'h1002);
    chk("clr_stalled_del", pc_del, 32'h200);
    clear = 0; stall = 0; btb = 1; btb_pc = 32'h4000;
    cyc(1);
    chk("supp_pc1", pc, 32'h1004);
    chk("supp_kill1", 32'(kill), 32'd0);
    cyc(1);
    chk("supp_pc2", pc, 32'h1006);
    chk("supp_pred2", 32'(pred_taken), 32'd0);
    cyc(1);
    chk("btb_pc", pc, 32'h4000);
    chk("btb_pred", 32'(pred_taken), 32'd1);
    chk("btb_kill", 32'(kill), 32'd1);
    chk("btb_valid", 32'(pc_valid), 32'd1);
    btb_pc = 32'h5000;
    cyc(1);
    chk("post_btb_pc1", pc, 32'h4002);
    chk("post_btb_kill1", 32'(kill), 32'd0);
    chk("post_btb_pred1", 32'(pred_taken), 32'd0);
    cyc(1);
    chk("post_btb_pc2", pc, 32'h4004);

    // Stall blocks BTB acceptance and holds state.
    stall = 1; btb_pc = 32'h6001;
    cyc(2);
    chk("stall_hold_pc", pc, 32'h4004);
    chk("stall_hold_kill", 32'(kill), 32'd0);
    stall = 0;
    cyc(1);
    chk("btb_thumb_align", pc, 32'h6000);
    btb = 0;
    cyc(1);
    chk("btb_adv", pc, 32'h6002);
    cyc(2);

    // Same-cycle execute redirect wins; BTB pulse is dropped and not replayed.
    thumb = 0; clear = 1; clear_pc = 32'h800; btb = 1; btb_pc = 32'h4000;
`ifdef ZAP_FETCH_REDIRECT_STATS_EN
    begin
      logic [31:0] s0;
      s0 = suppress_cnt;
      cyc(1);
      chk("stats_suppress_inc", suppress_cnt - s0, 32'd1);
    end
`else
    cyc(1);
`endif
    chk("clr_wins_pc", pc, 32'h800);
    chk("clr_wins_kill", 32'(kill), 32'd0);
    clear = 0; btb = 0;
    cyc(1);
    chk("no_replay_pc", pc, 32'h804);
    chk("no_replay_kill", 32'(kill), 32'd0);
    cyc(2);

    // ARM-state BTB target alignment.
    btb = 1; btb_pc = 32'h3007;
    cyc(1);
    chk("btb_arm_align", pc, 32'h3004);
    btb = 0;
    cyc(1);

    // Wrap at 2^32.
    clear = 1; clear_pc = 32'hFFFF_FFFC;
    cyc(1);
    clear = 0;
    cyc(1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_del", pc_del, 32'hFFFF_FFFC);
    cyc(1);

    // Reset while the suppress window is at one and a BTB pulse is present.
    clear = 1; clear_pc = 32'h2000;
    cyc(1);
    clear = 0;
    cyc(1);
    btb = 1; btb_pc = 32'h7000; reset = 1;
    cyc(1);
    chk("rst_mid_pc", pc, 32'h100);
    chk("rst_mid_kill", 32'(kill), 32'd0);
    chk("rst_mid_valid", 32'(pc_valid), 32'd0);
    reset = 0;
    cyc(1);
    chk("rst_mid_after_pc", pc, 32'h104);
    chk("rst_mid_after_kill", 32'(kill), 32'd0);
    btb = 0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zap_fetch_pc_gen.md
ZAP_FETCH_PC_GEN -- requirements
Module: zap_fetch_pc_gen

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0, the first fetch address after reset.
REQ-002 SHALL have i_clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have i_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have i_stall, input, 1, fetch hold (same signal driven to the BTB i_stall).
REQ-005 SHALL have i_clear, input, 1, execute-stage redirect (mispredict, exception, writeback to PC).
REQ-006 SHALL have i_clear_pc, input, 32, target address for i_clear.
REQ-007 SHALL have i_thumb, input, 1, current state: 1 means step 2, 0 means step 4.
REQ-008 SHALL have i_clear_from_btb, input, 1, BTB predicted-taken redirect.
REQ-009 SHALL have i_pc_from_btb, input, 32, BTB predicted target.
REQ-010 SHALL have o_pc, output, 32, current fetch address, driven to the I-side and BTB i_rd_addr.
REQ-011 SHALL have o_pc_del, output, 32, fetch address of the previous advance, driven to BTB i_rd_addr_del.
REQ-012 SHALL have o_pc_valid, output, 1, o_pc is a correct-path fetch.
REQ-013 SHALL have o_pred_taken, output, 1, the fetch at o_pc was reached through a BTB redirect.
REQ-014 SHALL have o_kill, output, 1, one-cycle pulse: discard all in-flight fetches younger than the predicted branch.

Function
REQ-015 Advance: when no redirect applies and i_stall=0, o_pc SHALL update to o_pc+2 (i_thumb=1) or o_pc+4 (i_thumb=0), mod 2^32 (0xFFFFFFFC+4 wraps to 0x0).
REQ-016 Every o_pc update (advance or redirect) SHALL load o_pc_del with the old o_pc. While i_stall=1 and i_clear=0, all outputs and state SHALL hold.
REQ-017 Priority SHALL be i_reset > i_clear > accepted BTB redirect > advance.
REQ-018 i_clear SHALL act regardless of i_stall. On the next edge: o_pc = aligned i_clear_pc, o_pred_taken = 0, o_kill = 0, suppress counter = 2.
REQ-019 Alignment SHALL force bit 0 to 0 when i_thumb=1 and bits [1:0] to 0 when i_thumb=0, for both i_clear_pc and i_pc_from_btb.
REQ-020 A 2-bit suppress counter SHALL mask i_clear_from_btb while nonzero. The counter decrements by 1 on each non-stalled cycle and saturates at 0. This covers the 2-cycle BTB lookup latency after any redirect.
REQ-021 A BTB redirect is accepted when i_clear_from_btb=1, i_clear=0, i_stall=0 and suppress counter = 0.
REQ-022 On an accepted BTB redirect, the next edge SHALL set: o_pc = aligned i_pc_from_btb, o_pred_taken = 1, o_kill = 1 for exactly one cycle, suppress counter = 2.
REQ-023 o_pred_taken SHALL clear on the next advance or i_clear.
REQ-024 o_pc_valid SHALL be 0 for one cycle after reset release and 1 thereafter. It SHALL never drop because of a BTB redirect.
REQ-025 A BTB redirect arriving on the same cycle as i_clear SHALL be dropped, and SHALL NOT be replayed.
REQ-026 o_kill SHALL never assert on consecutive cycles.

Reset
REQ-027 While i_reset=1, the following SHALL take effect at each edge: o_pc = RESET_VECTOR, o_pc_del = RESET_VECTOR, o_pc_valid = 0, o_pred_taken = 0, o_kill = 0, suppress counter = 2, and stats counters = 0.
REQ-028 Reset SHALL override i_clear, i_stall and i_clear_from_btb mid-operation. No redirect pending before reset SHALL survive it.

Configuration
REQ-029 With macro ZAP_FETCH_REDIRECT_STATS_EN defined, the block SHALL add two outputs:
- o_btb_redirect_cnt (32-bit): counts accepted BTB redirects.
- o_btb_suppress_cnt (32-bit): counts i_clear_from_btb pulses masked by REQ-020 or REQ-025.
Both counters SHALL wrap at 2^32.
REQ-030 Without ZAP_FETCH_REDIRECT_STATS_EN, these ports and their counters SHALL NOT exist. All other behaviour SHALL be identical.

Verification
REQ-031 Reset then release with RESET_VECTOR=0x100, i_thumb=0, no stalls -> o_pc = 0x100, 0x104, 0x108; o_pc_del lags by one step; o_pc_valid=0 in the first cycle only.
REQ-032 With o_pc=0x200, pulse i_clear with i_clear_pc=0x1003 and i_thumb=1 while i_stall=1 -> next o_pc = 0x1002. Then the o_pc sequence is 0x1004, 0x1006, and any i_clear_from_btb in the next 2 non-stalled cycles is ignored.
REQ-033 Suppress window expired, i_clear_from_btb=1, i_pc_from_btb=0x4000 -> next o_pc = 0x4000, o_pred_taken=1, o_kill=1 for one cycle. A BTB pulse on either of the next 2 cycles is ignored.
REQ-034 i_clear (target 0x800) and i_clear_from_btb (target 0x4000) on the same cycle -> o_pc = 0x800, o_kill=0; with stats enabled, o_btb_suppress_cnt increments by 1.
REQ-035 Advance from o_pc=0xFFFFFFFC, ARM state -> o_pc = 0x0. i_reset asserted while the suppress counter = 1 and a BTB pulse is pending -> o_pc = RESET_VECTOR, no o_kill.
